wupr_mb: RTL and testbench
==========================

# wupr_mb

Multi-bank, parametrised write-update partial-refresh tracker. The block records which row groups have been written since their last refresh slot, per bank. When the refresh scheduler offers a group, the block answers whether the group really needs refresh (`rsp_dref=1`) or can be skipped because a recent write already restored it (`rsp_dref=0`). It sits between the command scheduler (write observations, refresh offers) and the refresh engine (refresh/skip decisions). It generalises the single-bank tracker with bank count, group size, a request/response handshake, window clearing, a bypass enable and skip statistics.

## Interface
- `ROW_WIDTH`, 16, row address width
- `N`, 16, rows per group (power of two); `G_BITS = ROW_WIDTH - $clog2(N)` group index bits
- `BANKS`, 4, number of banks (power of two, ≥2); `B_BITS = $clog2(BANKS)`
- `CNT_WIDTH`, 16, skip-counter width

- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `wr_valid` in 1: a write to `wr_bank`/`wr_row` was issued this cycle
- `wr_bank` in B_BITS: bank of the write
- `wr_row` in ROW_WIDTH: row of the write; group is `wr_row[ROW_WIDTH-1 -: G_BITS]`
- `ref_valid` in 1: refresh offer for `ref_bank`/`ref_row` group
- `ref_ready` out 1: offer accepted when `ref_valid & ref_ready`
- `ref_bank` in B_BITS, `ref_row` in ROW_WIDTH: target of the offer
- `rsp_valid` out 1: decision available
- `rsp_ready` in 1: decision consumed when `rsp_valid & rsp_ready`
- `rsp_dref` out 1: 1 = perform refresh, 0 = skip
- `rsp_bank` out B_BITS, `rsp_row` out ROW_WIDTH: echo of the accepted offer
- `win_clear` in 1: refresh-window boundary pulse; clears all flags
- `wupr_en` in 1: 0 forces every decision to refresh
- `skip_cnt` out CNT_WIDTH: saturating count of skip decisions

## Operation
- State: flag array `F[BANKS][2^G_BITS]`, 1 bit per group. There is also a 1-entry response register.
- Write: `wr_valid` sets `F[wr_bank][grp(wr_row)]` at the clock edge. `wr_valid` has no handshake and is always absorbed.
- Offer accept: the block computes `hit = F[ref_bank][g] | (wr_valid & wr_bank==ref_bank & grp(wr_row)==g)`.
  - A same-cycle write bypasses into the lookup.
  - `rsp_dref = ~(hit & wupr_en)`.
  - If `wupr_en=1`, the flag is cleared at the edge, even when a same-cycle write targets it. If `wupr_en=0`, the flag is left unchanged.
- `win_clear`: all flags go to 0 at the edge. Priority per flag, low to high: win_clear clear < write set < offer clear.
  - An offer accepted in the same cycle as `win_clear` sees stored flags as 0. Only the write bypass can produce a skip in that cycle.
- `skip_cnt`: increments at accept when `rsp_dref` is 0. It saturates at all-ones and never wraps.
- Only offers with `ref_valid=1` are evaluated. Row bits below the group index are ignored for lookup but echoed unchanged on `rsp_row`.

## Timing
- Reset values: `F` all 0, `rsp_valid=0`, `rsp_dref=1`, `rsp_bank=0`, `rsp_row=0`, `skip_cnt=0`.
- `ref_ready = ~rsp_valid | rsp_ready` (combinational). There is no combinational path from `ref_valid` to `ref_ready`.
- Latency: an offer accepted at edge k produces `rsp_valid=1` with its decision after edge k. Back-to-back offers sustain 1 decision per cycle while `rsp_ready=1`.
- Response hold: `rsp_*` stay stable while `rsp_valid & ~rsp_ready`. `rsp_valid` falls after a consume edge unless a new offer is accepted on that same edge.
- A write at edge k is visible to the stored lookup from cycle k+1. In cycle k it is visible only through the bypass.
- Reset mid-operation: a pending response is dropped and all flags are lost. The first offer after reset always returns `rsp_dref=1`.
- `wupr_en` is sampled at the accept edge only.

## Test plan
- Reset, then offer bank 2 row 0x1230 → `rsp_dref=1` one cycle later, `skip_cnt=0`.
- Write bank 1 row 0x4567, then offer bank 1 row 0x4560 → `rsp_dref=0`, `skip_cnt=1`. A repeated offer for the same group → `rsp_dref=1`. An offer for bank 0 row 0x4560 → `rsp_dref=1`.
- Write and offer bank 3 row 0x00F0 in the same cycle → `rsp_dref=0`. The next offer for that group → `rsp_dref=1`. Repeat with `win_clear=1` in that cycle → still `rsp_dref=0`.
- Write bank 0 row 0x0010, pulse `win_clear`, then offer bank 0 row 0x0010 → `rsp_dref=1`. With `wupr_en=0` after a write → `rsp_dref=1`, and the flag survives: a later offer with `wupr_en=1` → 0.
- Hold `rsp_ready=0` for 3 cycles with `ref_valid=1` → `ref_ready=0`, `rsp_*` stable. Release → stream of 4 decisions in consecutive cycles, no loss or duplication.
- With `CNT_WIDTH=2`, 5 skip decisions → `skip_cnt` stays at 3. Assert `rst` while `rsp_valid=1` → all outputs at reset values immediately.

Source files
------------

// File: rtl/wupr_mb.sv
// Multi-bank write-update partial-refresh tracker. It remembers which row groups
// were written since their last refresh slot and answers refresh-or-skip for each offer.
module wupr_mb #(
  parameter int ROW_WIDTH = 16,
  parameter int N         = 16,
  parameter int BANKS     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  input  logic [$clog2(BANKS)-1:0]     wr_bank,
  input  logic [ROW_WIDTH-1:0]         wr_row,
  input  logic                         ref_valid,
  output logic                         ref_ready,
  input  logic [$clog2(BANKS)-1:0]     ref_bank,
  input  logic [ROW_WIDTH-1:0]         ref_row,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_dref,
  output logic [$clog2(BANKS)-1:0]     rsp_bank,
  output logic [ROW_WIDTH-1:0]         rsp_row,
  input  logic                         win_clear,
  input  logic                         wupr_en,
  output logic [CNT_WIDTH-1:0]         skip_cnt
);
  localparam int LOW_BITS = $clog2(N);
  localparam int G_BITS   = ROW_WIDTH - LOW_BITS;
  localparam int B_BITS   = $clog2(BANKS);
  localparam int GROUPS   = 1 << G_BITS;

  logic [G_BITS-1:0] wr_grp;
  logic [G_BITS-1:0] ref_grp;
  logic [BANKS-1:0]  stored_hit;
  logic              accept;
  logic              hit;
  logic              dref_next;

  assign wr_grp    = wr_row[ROW_WIDTH-1 -: G_BITS];
  assign ref_grp   = ref_row[ROW_WIDTH-1 -: G_BITS];
  assign ref_ready = ~rsp_valid | rsp_ready;
  assign accept    = ref_valid & ref_ready;

  generate
    if (LOW_BITS > 0) begin : g_low
      logic unused_wr_low;
      assign unused_wr_low = ^wr_row[LOW_BITS-1:0];
    end
  endgenerate

  // One flag row per bank; within a row the last assignment wins, giving
  // win_clear < write set < offer clear.
  genvar gi;
  generate
    for (gi = 0; gi < BANKS; gi++) begin : g_bank
      logic [GROUPS-1:0] flags;
      logic              wr_sel;
      logic              clr_sel;

      assign wr_sel     = wr_valid & (wr_bank == B_BITS'(gi));
      assign clr_sel    = accept & wupr_en & (ref_bank == B_BITS'(gi));
      assign stored_hit[gi] = flags[ref_grp];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          flags <= '0;
        end else begin
          if (win_clear) flags <= '0;
          if (wr_sel)    flags[wr_grp] <= 1'b1;
          if (clr_sel)   flags[ref_grp] <= 1'b0;
        end
      end
    end
  endgenerate

  // A window boundary in the accept cycle hides stored flags; only the
  // same-cycle write bypass can still yield a skip.
  always_comb begin
    hit = (stored_hit[ref_bank] & ~win_clear)
        | (wr_valid & (wr_bank == ref_bank) & (wr_grp == ref_grp));
    dref_next = ~(hit & wupr_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_dref  <= 1'b1;
      rsp_bank  <= '0;
      rsp_row   <= '0;
      skip_cnt  <= '0;
    end else begin
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_dref  <= dref_next;
        rsp_bank  <= ref_bank;
        rsp_row   <= ref_row;
        if (!dref_next && (skip_cnt != {CNT_WIDTH{1'b1}}))
          skip_cnt <= skip_cnt + CNT_WIDTH'(1);
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wupr_mb.sv
// Directed bench for wupr_mb with a 2-bit skip counter so saturation is reachable.
module tb_wupr_mb;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [1:0]  wr_bank;
  logic [15:0] wr_row;
  logic        ref_valid;
  logic        ref_ready;
  logic [1:0]  ref_bank;
  logic [15:0] ref_row;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_dref;
  logic [1:0]  rsp_bank;
  logic [15:0] rsp_row;
  logic        win_clear;
  logic        wupr_en;
  logic [1:0]  skip_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wupr_mb #(.ROW_WIDTH(16), .N(16), .BANKS(4), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_bank(wr_bank), .wr_row(wr_row),
    .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_bank(ref_bank), .ref_row(ref_row),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dref(rsp_dref),
    .rsp_bank(rsp_bank), .rsp_row(rsp_row),
    .win_clear(win_clear), .wupr_en(wupr_en), .skip_cnt(skip_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    wr_valid  = 1'b0;
    win_clear = 1'b0;
  endtask

  task automatic write(input logic [1:0] b, input logic [15:0] r);
    wr_valid = 1'b1; wr_bank = b; wr_row = r;
    tick();
  endtask

  // Offer one group (rsp_ready assumed high) and check the decision one edge later.
  task automatic offer(input string tag, input logic [1:0] b, input logic [15:0] r,
                       input logic exp_dref, input logic [1:0] exp_skip);
    ref_valid = 1'b1; ref_bank = b; ref_row = r;
    tick();
    ref_valid = 1'b0;
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_dref"},  32'(rsp_dref),  32'(exp_dref));
    chk({tag, "_bank"},  32'(rsp_bank),  32'(b));
    chk({tag, "_row"},   32'(rsp_row),   32'(r));
    chk({tag, "_skip"},  32'(skip_cnt),  32'(exp_skip));
    $display("offer %s bank=%0d row=%h dref=%0d skip=%0d", tag, b, r, rsp_dref, skip_cnt);
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_bank = '0; wr_row = '0;
    ref_valid = 1'b0; ref_bank = '0; ref_row = '0;
    rsp_ready = 1'b1; win_clear = 1'b0; wupr_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_dref",  32'(rsp_dref),  32'd1);
    chk("rst_row",   32'(rsp_row),   32'd0);
    chk("rst_skip",  32'(skip_cnt),  32'd0);
    chk("rst_ready", 32'(ref_ready), 32'd1);

    offer("cold", 2'd2, 16'h1230, 1'b1, 2'd0);

    write(2'd1, 16'h4567);
    offer("after_wr", 2'd1, 16'h4560, 1'b0, 2'd1);
    offer("repeat",   2'd1, 16'h4560, 1'b1, 2'd1);
    offer("oth_bank", 2'd0, 16'h4560, 1'b1, 2'd1);

    wr_valid = 1'b1; wr_bank = 2'd3; wr_row = 16'h00F0;
    offer("bypass",    2'd3, 16'h00F0, 1'b0, 2'd2);
    offer("byp_clr",   2'd3, 16'h00F0, 1'b1, 2'd2);
    wr_valid = 1'b1; wr_bank = 2'd3; wr_row = 16'h00F0; win_clear = 1'b1;
    offer("byp_wc",    2'd3, 16'h00F0, 1'b0, 2'd3);
    offer("byp_wc2",   2'd3, 16'h00F0, 1'b1, 2'd3);

    write(2'd0, 16'h0010);
    win_clear = 1'b1;
    tick();
    offer("win_clr",   2'd0, 16'h0010, 1'b1, 2'd3);
    write(2'd0, 16'h0010);
    wupr_en = 1'b0;
    offer("en_off",    2'd0, 16'h0010, 1'b1, 2'd3);
    wupr_en = 1'b1;
    offer("en_on_sat", 2'd0, 16'h001F, 1'b0, 2'd3);

    // Backpressure: A accepted then held while B waits; B..D stream after release.
    tick();
    chk("idle_valid", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;
    ref_valid = 1'b1; ref_bank = 2'd2; ref_row = 16'h1111;
    tick();
    ref_row = 16'h2222;
    wr_valid = 1'b1; wr_bank = 2'd2; wr_row = 16'h4444;
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", 32'(ref_ready), 32'd0);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_row",   32'(rsp_row),   32'h1111);
      chk("bp_dref",  32'(rsp_dref),  32'd1);
      $display("hold cycle %0d rsp_row=%h ref_ready=%0d", i, rsp_row, ref_ready);
      tick();
    end
    rsp_ready = 1'b1;
    #1 chk("rel_ready", 32'(ref_ready), 32'd1);
    tick();
    chk("strm_b_row", 32'(rsp_row), 32'h2222);
    chk("strm_b_val", 32'(rsp_valid), 32'd1);
    ref_row = 16'h3333;
    tick();
    chk("strm_c_row", 32'(rsp_row), 32'h3333);
    chk("strm_c_val", 32'(rsp_valid), 32'd1);
    ref_row = 16'h4449;
    tick();
    chk("strm_d_row",  32'(rsp_row),  32'h4449);
    chk("strm_d_dref", 32'(rsp_dref), 32'd0);
    chk("strm_d_skip", 32'(skip_cnt), 32'd3);
    $display("stream done row=%h dref=%0d skip=%0d", rsp_row, rsp_dref, skip_cnt);
    ref_valid = 1'b0;
    tick();
    chk("strm_end_val", 32'(rsp_valid), 32'd0);

    // Asynchronous reset with a held response pending.
    write(2'd1, 16'h7770);
    rsp_ready = 1'b0;
    ref_valid = 1'b1; ref_bank = 2'd3; ref_row = 16'hABCD;
    tick();
    ref_valid = 1'b0;
    chk("pre_rst_val", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_val",  32'(rsp_valid), 32'd0);
    chk("mid_rst_dref", 32'(rsp_dref),  32'd1);
    chk("mid_rst_bank", 32'(rsp_bank),  32'd0);
    chk("mid_rst_row",  32'(rsp_row),   32'd0);
    chk("mid_rst_skip", 32'(skip_cnt),  32'd0);
    $display("async reset rsp_valid=%0d skip=%0d", rsp_valid, skip_cnt);
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    offer("post_rst", 2'd1, 16'h7770, 1'b1, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
